// File: rtl/mult_sched.sv
// Round-robin front end for one shared sequential 32x32 multiplier.
// Grants one of two ports, clears and runs the multiplier, then returns the product.
module mult_sched #(
  parameter int ITER_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero,
  output logic        busy,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  output logic        m_rst_n,
  output logic        m_en,
  input  logic [31:0] m_hi,
  input  logic [31:0] m_lo
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [5:0] CNT_LAST = 6'(ITER_CYCLES - 1);

  state_t      r_state;
  logic        r_last, r_win;
  logic        r_gnt0, r_gnt1, r_done0, r_done1;
  logic        r_zero, r_busy, r_m_en;
  logic [31:0] r_hi, r_lo, r_m_a, r_m_b;
  logic [5:0]  r_cnt;
  logic        w_win;

  // Winner: sole requester, or the port not served last when both ask.
  assign w_win = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_zero  <= 1'b1;
      r_busy  <= 1'b0;
      r_m_a   <= '0;
      r_m_b   <= '0;
      r_m_en  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            r_win   <= w_win;
            r_last  <= w_win;
            r_m_a   <= w_win ? a1 : a0;
            r_m_b   <= w_win ? b1 : b0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_m_en  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          if (r_cnt == CNT_LAST) begin
            r_m_en  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          r_hi    <= m_hi;
          r_lo    <= m_lo;
          r_zero  <= ({m_hi, m_lo} == 64'd0);
          r_done0 <= ~r_win;
          r_done1 <= r_win;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Clear follows rst_n directly so the multiplier is held cleared during reset.
  assign m_rst_n = rst_n & (r_state != LOAD);
  assign m_en    = r_m_en;
  assign m_a     = r_m_a;
  assign m_b     = r_m_b;
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign zero    = r_zero;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural multiplier, table vectors, corner sequences, random ops.
module tb_mult_sched;
  localparam int ITER = 33;

  logic        clk = 0, rst_n = 0, req0 = 0, req1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        gnt0, gnt1, done0, done1, zero, busy, m_rst_n, m_en;
  logic [31:0] hi, lo, m_a, m_b, m_hi, m_lo;

  int total = 0, bad = 0;
  bit last_m = 1'b1;

  mult_sched #(.ITER_CYCLES(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .hi(hi), .lo(lo), .zero(zero), .busy(busy),
    .m_a(m_a), .m_b(m_b), .m_rst_n(m_rst_n), .m_en(m_en),
    .m_hi(m_hi), .m_lo(m_lo)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product appears only after exactly ITER enabled edges since clear.
  int mcnt = 0;
  always @(posedge clk) begin
    if (!m_rst_n) begin
      mcnt <= 0;
      {m_hi, m_lo} <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (m_en) begin
      mcnt <= mcnt + 1;
      if (mcnt == ITER - 1) {m_hi, m_lo} <= 64'(m_a) * 64'(m_b);
      else {m_hi, m_lo} <= 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 0; req0 = 0; req1 = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    last_m = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},  {gnt0, gnt1}, 2'b00);
    chk({tag, "_done"}, {done0, done1}, 2'b00);
    chk({tag, "_hilo"}, {hi, lo}, 64'd0);
    chk({tag, "_zero"}, zero, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mab"},  {m_a, m_b}, 64'd0);
    chk({tag, "_men"},  m_en, 1'b0);
    chk({tag, "_mrst"}, m_rst_n, 1'b0);
  endtask

  // One request episode starting from IDLE; requests drop once granted.
  task automatic run_op(input string tag, input logic [1:0] mask,
                        input logic [31:0] xa0, xb0, xa1, xb1,
                        input int port, input bit perturb);
    int gc, dc;
    bit other;
    logic [63:0] p;
    logic [31:0] ea, eb;
    ea = port ? xa1 : xa0;
    eb = port ? xb1 : xb0;
    p  = 64'(ea) * 64'(eb);
    gc = -1; dc = -1; other = 0;
    tick();
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    req0 = mask[0]; req1 = mask[1];
    for (int k = 1; k <= 60 && dc < 0; k++) begin
      tick();
      if (gnt0 | gnt1) begin
        if (gc < 0) gc = k;
        if ((port == 0 && gnt1) || (port == 1 && gnt0)) other = 1;
        req0 = 0; req1 = 0;
      end
      if (k == 1) begin
        chk({tag, "_busy_load"}, busy, 1'b1);
        chk({tag, "_mrst_load"}, m_rst_n, 1'b0);
      end
      if (perturb && k == 10) begin
        a0 = ~xa0; b0 = xb0 + 32'd7; a1 = ~xa1; b1 = xb1 + 32'd7;
      end
      if (perturb && k == 11) chk({tag, "_mab_stable"}, {m_a, m_b}, {ea, eb});
      if (done0 | done1) begin
        dc = k;
        if ((port == 0 && done1) || (port == 1 && done0)) other = 1;
        chk({tag, "_hilo"}, {hi, lo}, p);
        chk({tag, "_zero"}, zero, p == 64'd0);
        chk({tag, "_busy_done"}, busy, 1'b0);
      end
    end
    chk({tag, "_gnt_cycle"}, gc, 1);
    chk({tag, "_done_cycle"}, dc, 36);
    chk({tag, "_wrong_port"}, other, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] a0, b0, a1, b1;
    int          port;
    logic [31:0] ehi, elo;
    logic        ez;
  } vec_t;

  initial begin
    vec_t vt[6];
    int gcyc[8], gport[8], dcyc[8], dport[8];
    logic [63:0] dval[8];
    int ng, nd;
    logic [63:0] p;

    vt[0] = '{2'b01, 32'd3, 32'd5, 32'd0, 32'd0, 0, 32'd0, 32'd15, 1'b0};
    vt[1] = '{2'b10, 32'd0, 32'd0, 32'h0001_0000, 32'h0001_0000, 1, 32'd1, 32'd0, 1'b0};
    vt[2] = '{2'b01, 32'd0, 32'h1234, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b1};
    vt[3] = '{2'b11, 32'd2, 32'd3, 32'd7, 32'd9, 1, 32'd0, 32'd63, 1'b0};
    vt[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 32'hFFFF_FFFE, 32'd1, 1'b0};
    vt[5] = '{2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 32'hFFFF_FFFE, 1'b0};

    #12;
    chk_reset_vals("in_reset");
    @(negedge clk) rst_n = 1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].mask, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1,
             vt[i].port, 1'b0);
      chk($sformatf("vec%0d_const", i), {hi, lo, 31'd0, zero}, {vt[i].ehi, vt[i].elo, 31'd0, vt[i].ez});
    end
    last_m = 1'b1;

    // Reset while RUN: result discarded, no done.
    tick();
    a0 = 32'd9; b0 = 32'd9; req0 = 1;
    for (int k = 1; k < 20; k++) tick();
    rst_n = 0;
    #1;
    chk_reset_vals("rst_run");
    @(negedge clk);
    rst_n = 1; req0 = 0;
    ng = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (gnt0 | gnt1 | done0 | done1) ng++;
    end
    chk("rst_run_quiet", ng, 0);
    run_op("after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd0, 0, 1'b0);

    run_op("stable", 2'b10, 32'd0, 32'd0, 32'h8000_0001, 32'h0000_0003, 1, 1'b1);

    // Contention from reset with both held: strict alternation.
    pulse_reset();
    ng = 0; nd = 0;
    tick();
    a0 = 32'd11; b0 = 32'd13; a1 = 32'd17; b1 = 32'd19;
    req0 = 1; req1 = 1;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if ((gnt0 | gnt1) && ng < 8) begin
        gcyc[ng] = k; gport[ng] = gnt1; ng++;
        if (ng == 4) begin req0 = 0; req1 = 0; end
      end
      if ((done0 | done1) && nd < 8) begin
        dcyc[nd] = k; dport[nd] = done1; dval[nd] = {hi, lo}; nd++;
      end
    end
    chk("cont_ngnt", ng, 4);
    chk("cont_ndone", nd, 4);
    for (int i = 0; i < 4 && i < ng && i < nd; i++) begin
      chk($sformatf("cont_gcyc%0d", i), gcyc[i], 1 + 36 * i);
      chk($sformatf("cont_gport%0d", i), gport[i], i % 2);
      chk($sformatf("cont_dcyc%0d", i), dcyc[i], 36 * (i + 1));
      chk($sformatf("cont_dport%0d", i), dport[i], i % 2);
      chk($sformatf("cont_val%0d", i), dval[i], (i % 2) ? 64'd323 : 64'd143);
    end
    last_m = 1'b1;

    // Random ops against the arbitration and arithmetic model.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] m;
      logic [31:0] ra0, rb0, ra1, rb1;
      int w;
      m = 2'($urandom_range(1, 3));
      ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ra1 = $urandom; rb1 = $urandom;
      w = (m == 2'b11) ? int'(!last_m) : int'(m == 2'b10);
      last_m = w[0];
      run_op($sformatf("rnd%0d", i), m, ra0, rb0, ra1, rb1, w, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
